// File: rtl/hdpldadapt_cmn_occ_capture_sequencer_if.sv
// hdpldadapt_cmn_occ_capture_sequencer_if: ATPG capture control and OCC clock-gate enable bundle
interface hdpldadapt_cmn_occ_capture_sequencer_if #(
  parameter int NUM_DOM = 4,
  parameter int CNT_W   = 2
);
  logic                     atpg_mode;
  logic                     scan_enable;
  logic [NUM_DOM-1:0]       dom_mask;
  logic [NUM_DOM*CNT_W-1:0] pulse_cnt;
  logic [NUM_DOM-1:0]       occ_clken;
  logic                     busy;
  logic                     done;
  logic                     abort;
  modport master (
    output atpg_mode, scan_enable, dom_mask, pulse_cnt,
    input  occ_clken, busy, done, abort
  );
  modport slave (
    input  atpg_mode, scan_enable, dom_mask, pulse_cnt,
    output occ_clken, busy, done, abort
  );
endinterface

// File: rtl/hdpldadapt_cmn_occ_capture_sequencer.sv
// hdpldadapt_cmn_occ_capture_sequencer: schedules per-domain OCC capture bursts after each scan_enable fall
module hdpldadapt_cmn_occ_capture_sequencer #(
  parameter int NUM_DOM    = 4,
  parameter int CNT_W      = 2,
  parameter int SETTLE_CYC = 4,
  parameter int GAP_CYC    = 2
) (
  input logic test_clk,
  input logic rst_n,
  hdpldadapt_cmn_occ_capture_sequencer_if.slave bus
);
  localparam int TMR_MAX = (SETTLE_CYC > GAP_CYC) ? SETTLE_CYC : GAP_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX) + 1;
  localparam int SEL_W   = (NUM_DOM > 1) ? $clog2(NUM_DOM) : 1;
  localparam int PC_W    = CNT_W + 1;
  typedef enum logic [2:0] {IDLE, SETTLE, BURST, GAP, DONE} state_t;
  state_t                   state_q, state_d;
  logic                     se_q;
  logic [NUM_DOM-1:0]       rem_q, rem_d, rem_clr;
  logic [NUM_DOM*CNT_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0]         sel_q, sel_d;
  logic [PC_W-1:0]          pc_q, pc_d;
  logic [TMR_W-1:0]         tmr_q, tmr_d;
  logic [NUM_DOM-1:0]       clken_q, clken_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     abort_q, abort_d;
  logic                     launch;
  function automatic logic [SEL_W-1:0] lowest(input logic [NUM_DOM-1:0] m);
    lowest = '0;
    for (int i = NUM_DOM - 1; i >= 0; i--)
      if (m[i]) lowest = SEL_W'(i);
  endfunction
  // Next state, latched capture setup, counters and registered outputs
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    pc_d    = pc_q;
    tmr_d   = tmr_q;
    clken_d = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    abort_d = 1'b0;
    launch  = 1'b0;
    rem_clr = rem_q & ~(NUM_DOM'(1) << sel_q);
    if (!bus.atpg_mode) state_d = IDLE;
    else begin
      case (state_q)
        IDLE: if (se_q && !bus.scan_enable) begin
          rem_d   = bus.dom_mask;
          cnt_d   = bus.pulse_cnt;
          tmr_d   = TMR_W'(SETTLE_CYC);
          busy_d  = 1'b1;
          state_d = SETTLE;
        end
        SETTLE, GAP: if (bus.scan_enable) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end else if (tmr_q == TMR_W'(1)) begin
          if (rem_q == '0) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else launch = 1'b1;
        end else begin
          tmr_d  = tmr_q - TMR_W'(1);
          busy_d = 1'b1;
        end
        BURST: if (bus.scan_enable) begin
          abort_d = 1'b1;
          state_d = IDLE;
        end else if (pc_q == PC_W'(1)) begin
          rem_d = rem_clr;
          if (rem_clr == '0) begin
            done_d  = 1'b1;
            state_d = DONE;
          end else if (GAP_CYC == 0) launch = 1'b1;
          else begin
            tmr_d   = TMR_W'(GAP_CYC);
            busy_d  = 1'b1;
            state_d = GAP;
          end
        end else begin
          pc_d    = pc_q - PC_W'(1);
          clken_d = clken_q;
          busy_d  = 1'b1;
        end
        DONE: if (bus.scan_enable) state_d = IDLE;
          else done_d = 1'b1;
        default: state_d = IDLE;
      endcase
    end
    if (launch) begin
      sel_d   = lowest(rem_d);
      pc_d    = PC_W'(cnt_q[sel_d*CNT_W +: CNT_W]) + PC_W'(1);
      clken_d = NUM_DOM'(1) << sel_d;
      busy_d  = 1'b1;
      state_d = BURST;
    end
  end
  // State and output registers with asynchronous clear
  always_ff @(posedge test_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      se_q    <= 1'b0;
      rem_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      pc_q    <= '0;
      tmr_q   <= '0;
      clken_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      se_q    <= bus.scan_enable;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      pc_q    <= pc_d;
      tmr_q   <= tmr_d;
      clken_q <= clken_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      abort_q <= abort_d;
    end
  end
  assign bus.occ_clken = clken_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.abort     = abort_q;
  a_onehot_clken: assert property (@(posedge test_clk) disable iff (!rst_n) $onehot0(clken_q));
  a_done_not_busy: assert property (@(posedge test_clk) disable iff (!rst_n) !(done_q && busy_q));
endmodule

// File: tb/tb_hdpldadapt_cmn_occ_capture_sequencer.sv
// tb_hdpldadapt_cmn_occ_capture_sequencer: scoreboard bench with two gap settings and a cycle-level reference model
module tb_hdpldadapt_cmn_occ_capture_sequencer;
  localparam int SETTLE = 4;
  logic clk = 1'b0;
  logic rst_n;
  logic se, atpg;
  logic [3:0] mask;
  logic [7:0] cnt;
  logic [13:0] exp_q[$];
  int total = 0;
  int bad = 0;
  hdpldadapt_cmn_occ_capture_sequencer_if #(.NUM_DOM(4), .CNT_W(2)) bus2();
  hdpldadapt_cmn_occ_capture_sequencer_if #(.NUM_DOM(4), .CNT_W(2)) bus0();
  assign bus2.scan_enable = se;
  assign bus2.atpg_mode   = atpg;
  assign bus2.dom_mask    = mask;
  assign bus2.pulse_cnt   = cnt;
  assign bus0.scan_enable = se;
  assign bus0.atpg_mode   = atpg;
  assign bus0.dom_mask    = mask;
  assign bus0.pulse_cnt   = cnt;
  hdpldadapt_cmn_occ_capture_sequencer #(.NUM_DOM(4), .CNT_W(2), .SETTLE_CYC(SETTLE), .GAP_CYC(2)) u_dut2 (
    .test_clk(clk), .rst_n(rst_n), .bus(bus2));
  hdpldadapt_cmn_occ_capture_sequencer #(.NUM_DOM(4), .CNT_W(2), .SETTLE_CYC(SETTLE), .GAP_CYC(0)) u_dut0 (
    .test_clk(clk), .rst_n(rst_n), .bus(bus0));
  always #5 clk = ~clk;
  // Expected {abort,done,busy,clken} c cycles after the capture-start cycle, undisturbed sequence
  function automatic logic [6:0] ideal(input int c, input int g, input logic [3:0] m, input logic [7:0] p);
    int t, n;
    bit first;
    if (c == 0) return 7'h00;
    if (c <= SETTLE) return 7'h10;
    t = SETTLE + 1;
    first = 1'b1;
    for (int d = 0; d < 4; d++) begin
      if (m[d]) begin
        if (!first) begin
          if (c < t + g) return 7'h10;
          t += g;
        end
        n = int'(p[d*2 +: 2]) + 1;
        if (c < t + n) return 7'h10 | (7'h01 << d);
        t += n;
        first = 1'b0;
      end
    end
    return 7'h20;
  endfunction
  // kind 0: scan_enable rises at ev; kind 1: atpg_mode low at ev; kind 2: reset asserted during ev
  function automatic logic [6:0] model_out(input int c, input int g, input logic [3:0] m, input logic [7:0] p,
                                           input int ev, input int kind);
    logic [6:0] at_ev;
    at_ev = ideal(ev, g, m, p);
    if (kind == 2) return (c < ev) ? ideal(c, g, m, p) : 7'h00;
    if (c <= ev) return ideal(c, g, m, p);
    if (c == ev + 1 && kind == 0 && at_ev[4]) return 7'h40;
    return 7'h00;
  endfunction
  task automatic chk(input string name, input logic [6:0] act, input logic [6:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s t=%0t got {abort,done,busy,clken}=%b want %b", name, $time, act, req);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(14'h0);
      cyc();
    end
  endtask
  task automatic run_capture(input logic [3:0] m, input logic [7:0] p, input int ev, input int kind);
    se = 1'b1;
    atpg = 1'b1;
    mask = m;
    cnt = p;
    idle_cycles(2);
    for (int c = 0; c <= ev + 3; c++) begin
      if (kind == 2 && c == ev + 1) rst_n = 1'b1;
      se = ((kind == 0 && c >= ev) || (kind != 0 && c >= ev + 2)) ? 1'b1 : 1'b0;
      atpg = !(kind == 1 && c == ev);
      mask = (c == 0) ? m : 4'($urandom);
      cnt = (c == 0) ? p : 8'($urandom);
      exp_q.push_back({model_out(c, 0, m, p, ev, kind), model_out(c, 2, m, p, ev, kind)});
      if (kind == 2 && c == ev) begin
        #1 rst_n = 1'b0;
        #1;
        chk("async_reset_g2", {bus2.abort, bus2.done, bus2.busy, bus2.occ_clken}, 7'h00);
        chk("async_reset_g0", {bus0.abort, bus0.done, bus0.busy, bus0.occ_clken}, 7'h00);
      end
      cyc();
    end
    se = 1'b1;
    atpg = 1'b1;
  endtask
  // Monitor: pops one expectation per cycle and compares both DUTs mid-cycle
  always @(negedge clk) begin
    logic [13:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("dut_gap2", {bus2.abort, bus2.done, bus2.busy, bus2.occ_clken}, e[6:0]);
      chk("dut_gap0", {bus0.abort, bus0.done, bus0.busy, bus0.occ_clken}, e[13:7]);
    end
  end
  initial begin
    int k;
    rst_n = 1'b0;
    se = 1'b1;
    atpg = 1'b1;
    mask = '0;
    cnt = '0;
    #3;
    chk("reset_g2", {bus2.abort, bus2.done, bus2.busy, bus2.occ_clken}, 7'h00);
    chk("reset_g0", {bus0.abort, bus0.done, bus0.busy, bus0.occ_clken}, 7'h00);
    cyc();
    cyc();
    rst_n = 1'b1;
    run_capture(4'b0101, 8'b00_10_00_01, 15, 0);
    run_capture(4'b0000, 8'h00, 8, 0);
    run_capture(4'b1111, 8'hFF, 22, 0);
    run_capture(4'b1111, 8'hFF, 12, 0);
    run_capture(4'b1111, 8'hFF, 6, 1);
    se = 1'b1;
    atpg = 1'b0;
    idle_cycles(2);
    se = 1'b0;
    idle_cycles(6);
    run_capture(4'b0101, 8'b00_10_00_01, 7, 2);
    run_capture(4'b0101, 8'b00_10_00_01, 14, 0);
    run_capture(4'b1000, 8'b11_00_00_00, 9, 0);
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 9);
      run_capture(4'($urandom), 8'($urandom), $urandom_range(1, 30), (k < 6) ? 0 : (k < 8) ? 1 : 2);
    end
    idle_cycles(2);
    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
